// File: rtl/memory_256x16.sv
// 256 x 16 single-clock RAM with two muxed access ports (loader / processor).
// Asynchronous read, synchronous write, synchronous clear-all reset.
module memory_256x16 (
    input  logic        clk_n,
    input  logic        rst,
    input  logic        Tbornot,
    input  logic [7:0]  Addr_tb,
    input  logic [7:0]  Addr_pc,
    input  logic [15:0] Data_tb,
    input  logic [15:0] Data_pc,
    input  logic        WE_tb,
    input  logic        WE_pc,
    output logic [15:0] MemOut
);

    logic [15:0] mem_q [256];
    logic [7:0]  sel_addr;
    logic [15:0] sel_data;
    logic        sel_we;

    // The unselected port is fully masked, including its write enable.
    always_comb begin
        sel_addr = Addr_pc;
        sel_data = Data_pc;
        sel_we   = WE_pc;
        if (Tbornot) begin
            sel_addr = Addr_tb;
            sel_data = Data_tb;
            sel_we   = WE_tb;
        end
    end

    // Reset wins over a same-edge write.
    always_ff @(posedge clk_n) begin
        if (rst) begin
            for (int unsigned i = 0; i < 256; i++) begin
                mem_q[i] <= '0;
            end
        end else if (sel_we) begin
            mem_q[sel_addr] <= sel_data;
        end
    end

    assign MemOut = mem_q[sel_addr];

endmodule

// File: tb/tb_memory_256x16.sv
// Directed and model-checked random stimulus for memory_256x16.
module tb_memory_256x16;

    logic        clk_n = 1'b0;
    logic        rst;
    logic        Tbornot;
    logic [7:0]  Addr_tb;
    logic [7:0]  Addr_pc;
    logic [15:0] Data_tb;
    logic [15:0] Data_pc;
    logic        WE_tb;
    logic        WE_pc;
    logic [15:0] MemOut;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] ref_mem [256];

    memory_256x16 dut (
        .clk_n   (clk_n),
        .rst     (rst),
        .Tbornot (Tbornot),
        .Addr_tb (Addr_tb),
        .Addr_pc (Addr_pc),
        .Data_tb (Data_tb),
        .Data_pc (Data_pc),
        .WE_tb   (WE_tb),
        .WE_pc   (WE_pc),
        .MemOut  (MemOut)
    );

    always #5 clk_n = ~clk_n;

    task automatic check_out(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Inputs change 3 ns after the rising edge, well clear of the next edge.
    task automatic tick();
        @(posedge clk_n);
        #3;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  a;
        logic [15:0] d;

        rst = 1'b1; Tbornot = 1'b1;
        Addr_tb = '0; Addr_pc = '0; Data_tb = '0; Data_pc = '0;
        WE_tb = 1'b0; WE_pc = 1'b0;
        tick();
        rst = 1'b0;

        // Every word reads zero after reset.
        for (int i = 0; i < 256; i++) begin
            Addr_tb = 8'(i);
            #1;
            check_out($sformatf("reset_sweep_%02h", i), MemOut, 16'h0000);
        end
        tick();

        // Loader write, processor read-back.
        Tbornot = 1'b1; WE_tb = 1'b1; Addr_tb = 8'h12; Data_tb = 16'hBEEF;
        tick();
        check_out("raw_tb_12", MemOut, 16'hBEEF);
        WE_tb = 1'b0; Tbornot = 1'b0; Addr_pc = 8'h12; WE_pc = 1'b0;
        #1;
        check_out("pc_read_12", MemOut, 16'hBEEF);

        // Both WEs high: only the processor port writes.
        Tbornot = 1'b0;
        WE_pc = 1'b1; Addr_pc = 8'hFF; Data_pc = 16'h1234;
        WE_tb = 1'b1; Addr_tb = 8'hFF; Data_tb = 16'hAAAA;
        tick();
        WE_pc = 1'b0; WE_tb = 1'b0;
        #1;
        check_out("dual_we_pc_ff", MemOut, 16'h1234);
        Tbornot = 1'b1;
        #1;
        check_out("dual_we_tb_ff", MemOut, 16'h1234);

        // Unselected processor WE must not write.
        Tbornot = 1'b1; WE_tb = 1'b0; Addr_tb = 8'h12;
        WE_pc = 1'b1; Addr_pc = 8'h12; Data_pc = 16'h0000;
        tick();
        WE_pc = 1'b0;
        #1;
        check_out("unsel_we_12", MemOut, 16'hBEEF);

        // Combinational read follows address with no clock edge.
        Tbornot = 1'b0; WE_pc = 1'b1; Addr_pc = 8'h40; Data_pc = 16'h0001;
        tick();
        WE_pc = 1'b0;
        #1;
        check_out("comb_40_a", MemOut, 16'h0001);
        Addr_pc = 8'h41;
        #1;
        check_out("comb_41", MemOut, 16'h0000);
        Addr_pc = 8'h40;
        #1;
        check_out("comb_40_b", MemOut, 16'h0001);

        // Reset discards a same-edge write and clears prior contents.
        Tbornot = 1'b1; WE_tb = 1'b1; Addr_tb = 8'h00; Data_tb = 16'h5A5A; rst = 1'b1;
        tick();
        rst = 1'b0; WE_tb = 1'b0;
        #1;
        check_out("rst_wr_00", MemOut, 16'h0000);
        Addr_tb = 8'h12; #1; check_out("rst_clr_12", MemOut, 16'h0000);
        Addr_tb = 8'hFF; #1; check_out("rst_clr_ff", MemOut, 16'h0000);
        Addr_tb = 8'h40; #1; check_out("rst_clr_40", MemOut, 16'h0000);

        // Random traffic against a behavioural reference.
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
        for (int n = 0; n < 60; n++) begin
            Tbornot = 1'($urandom);
            WE_tb   = 1'($urandom); Addr_tb = 8'($urandom_range(0, 15)); Data_tb = 16'($urandom);
            WE_pc   = 1'($urandom); Addr_pc = 8'($urandom_range(0, 15)); Data_pc = 16'($urandom);
            #1;
            a = Tbornot ? Addr_tb : Addr_pc;
            check_out($sformatf("rand_%0d_pre", n), MemOut, ref_mem[a]);
            if (Tbornot ? WE_tb : WE_pc) begin
                d = Tbornot ? Data_tb : Data_pc;
                ref_mem[a] = d;
            end
            tick();
            check_out($sformatf("rand_%0d_post", n), MemOut, ref_mem[a]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
